// File: rtl/bcd_display_converter_if.sv
// Request/result bundle between a level source, the BCD converter and the display mux.
// The master side issues values and consumes digits; the slave side is the converter.
interface bcd_display_converter_if #(
  parameter int IN_W = 10
);
  logic [IN_W-1:0] value;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      num2;
  logic [3:0]      num1;
  logic [3:0]      num0;
  logic            neg;
  logic            sat;
  logic            out_valid;

  modport master (
    output value,
    output in_valid,
    input  in_ready,
    input  num2,
    input  num1,
    input  num0,
    input  neg,
    input  sat,
    input  out_valid
  );

  modport slave (
    input  value,
    input  in_valid,
    output in_ready,
    output num2,
    output num1,
    output num0,
    output neg,
    output sat,
    output out_valid
  );
endinterface

// File: rtl/bcd_display_converter.sv
// Signed level to three held BCD digits plus sign/saturation flags, using a
// ten-step shift-add-3 engine behind a valid/ready request handshake.
module bcd_display_converter #(
  parameter int IN_W    = 10,
  parameter int SAT_MAX = 999
) (
  input  logic                    clk,
  input  logic                    reset_n,
  bcd_display_converter_if.slave  bus
);

  localparam int MW = IN_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [9:0]  bin_q;
  logic [11:0] bcd_q;
  logic [3:0]  cnt_q;
  logic        sign_q;
  logic        satr_q;

  logic [3:0]  num2_q;
  logic [3:0]  num1_q;
  logic [3:0]  num0_q;
  logic        neg_q;
  logic        sat_q;

  logic        accept;
  logic        last_iter;

  logic [MW-1:0] ext;
  logic [MW-1:0] mag;
  logic [16:0]   mag_wide;
  logic          sat_c;
  logic          sign_c;
  logic [9:0]    clamped;

  logic [11:0] adj;
  logic [11:0] bcd_n;
  logic [9:0]  bin_n;

  // Magnitude is taken one bit wider than the input so -2^(IN_W-1) survives negation.
  always_comb begin
    ext      = {bus.value[IN_W-1], bus.value};
    mag      = ext[MW-1] ? (~ext + 1'b1) : ext;
    mag_wide = 17'(mag);
    sat_c    = (mag_wide > 17'(SAT_MAX));
    sign_c   = bus.value[IN_W-1] && (mag_wide != '0);
    clamped  = sat_c ? 10'(SAT_MAX) : mag_wide[9:0];
  end

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    {bcd_n, bin_n} = {adj, bin_q} << 1;
  end

  assign bus.in_ready = (state_q != SHIFT);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_iter    = (cnt_q == 4'd9);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        state_d       = accept ? SHIFT : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      satr_q <= 1'b0;
    end else if (accept) begin
      bin_q  <= clamped;
      bcd_q  <= '0;
      cnt_q  <= '0;
      sign_q <= sign_c;
      satr_q <= sat_c;
    end else if (state_q == SHIFT) begin
      bin_q <= bin_n;
      bcd_q <= bcd_n;
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Display registers load straight from the final iteration so they update on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num2_q <= '0;
      num1_q <= '0;
      num0_q <= '0;
      neg_q  <= 1'b0;
      sat_q  <= 1'b0;
    end else if ((state_q == SHIFT) && last_iter) begin
      num2_q <= bcd_n[11:8];
      num1_q <= bcd_n[7:4];
      num0_q <= bcd_n[3:0];
      neg_q  <= sign_q;
      sat_q  <= satr_q;
    end
  end

  assign bus.num2 = num2_q;
  assign bus.num1 = num1_q;
  assign bus.num0 = num0_q;
  assign bus.neg  = neg_q;
  assign bus.sat  = sat_q;

endmodule

// File: tb/tb_bcd_display_converter.sv
// Bench for bcd_display_converter: a 10-bit and a 12-bit instance checked against
// a decimal-arithmetic reference for digits, flags, latency and output holding.
module tb_bcd_display_converter;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  bcd_display_converter_if #(.IN_W(10)) ifa ();
  bcd_display_converter_if #(.IN_W(12)) ifb ();

  bcd_display_converter #(.IN_W(10), .SAT_MAX(999)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  bcd_display_converter #(.IN_W(12), .SAT_MAX(999)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  int errors = 0;
  int checks = 0;
  int prev [2];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packed as {sat, neg, hundreds, tens, units}.
  function automatic int ref_conv(input int v);
    int mag;
    int s;
    int n;
    mag = (v < 0) ? -v : v;
    s   = (mag > 999) ? 1 : 0;
    if (s == 1) mag = 999;
    n   = ((v < 0) && (mag != 0)) ? 1 : 0;
    return (s << 13) | (n << 12) | ((mag / 100) << 8) | (((mag / 10) % 10) << 4) | (mag % 10);
  endfunction

  function automatic int outs(input int s);
    if (s == 0)
      return int'({ifa.sat, ifa.neg, ifa.num2, ifa.num1, ifa.num0});
    return int'({ifb.sat, ifb.neg, ifb.num2, ifb.num1, ifb.num0});
  endfunction

  function automatic int ovf(input int s);
    return (s == 0) ? int'(ifa.out_valid) : int'(ifb.out_valid);
  endfunction

  function automatic int rdy(input int s);
    return (s == 0) ? int'(ifa.in_ready) : int'(ifb.in_ready);
  endfunction

  task automatic drive(input int s, input int v, input bit vld);
    if (s == 0) begin
      ifa.value    = v[9:0];
      ifa.in_valid = vld;
    end else begin
      ifb.value    = v[11:0];
      ifb.in_valid = vld;
    end
  endtask

  // Called at a negedge with the converter idle; returns at the negedge after the accept.
  task automatic send(input int s, input int v);
    check("send_ready", rdy(s), 1);
    drive(s, v, 1'b1);
    @(negedge clk);
    check("busy_ready", rdy(s), 0);
    drive(s, int'($urandom), 1'b0);
  endtask

  // Returns at the negedge of the out_valid cycle, where a back-to-back send may follow.
  task automatic await_result(input int s, input int v);
    int lat;
    int held;
    int e;
    lat  = 0;
    held = 1;
    e    = ref_conv(v);
    while ((ovf(s) == 0) && (lat < 20)) begin
      @(negedge clk);
      lat++;
      if (ovf(s) == 0) begin
        if (outs(s) != prev[s]) held = 0;
        if (lat < 8) drive(s, int'($urandom), 1'($urandom_range(0, 1)));
        else drive(s, int'($urandom), 1'b0);
      end
    end
    check("latency", lat, 10);
    check("hold", held, 1);
    check($sformatf("result(%0d)", v), outs(s), e);
    prev[s] = e;
  endtask

  task automatic conv(input int s, input int v, input bit b2b);
    send(s, v);
    await_result(s, v);
    if (!b2b) begin
      @(negedge clk);
      check("pulse_width", ovf(s), 0);
      check("idle_ready", rdy(s), 1);
    end
  endtask

  initial begin
    int seen;
    int s;
    int v;
    bit b2b;

    reset_n = 1'b0;
    drive(0, 0, 1'b0);
    drive(1, 0, 1'b0);
    prev[0] = 0;
    prev[1] = 0;

    repeat (3) @(negedge clk);
    check("reset_out_a", outs(0), 0);
    check("reset_out_b", outs(1), 0);
    check("reset_rdy_a", rdy(0), 1);
    check("reset_ov_a", ovf(0), 0);
    reset_n = 1'b1;

    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if ((ovf(0) != 0) || (ovf(1) != 0)) seen = 1;
    end
    check("idle_no_pulse", seen, 0);
    check("idle_out_a", outs(0), 0);
    check("idle_rdy_b", rdy(1), 1);

    conv(0, 123, 1'b0);
    conv(0, -45, 1'b1);
    conv(0, -512, 1'b0);
    conv(0, 0, 1'b0);
    conv(0, 9, 1'b0);
    conv(1, 2047, 1'b0);
    conv(1, -1000, 1'b1);
    conv(1, 999, 1'b0);
    conv(1, -2048, 1'b0);

    // Abort a conversion partway through with reset.
    send(0, 321);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_async_out", outs(0), 0);
    check("rst_async_out_b", outs(1), 0);
    check("rst_async_rdy", rdy(0), 1);
    @(negedge clk);
    reset_n = 1'b1;
    prev[0] = 0;
    prev[1] = 0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (ovf(0) != 0) seen = 1;
    end
    check("rst_no_pulse", seen, 0);
    check("rst_hold_out", outs(0), 0);
    conv(0, 321, 1'b0);

    for (int i = 0; i < 60; i++) begin
      s   = int'($urandom_range(0, 1));
      v   = (s == 0) ? int'($urandom_range(0, 1023)) - 512 : int'($urandom_range(0, 4095)) - 2048;
      b2b = 1'($urandom_range(0, 1));
      conv(s, v, b2b);
      if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
